// File: rtl/acc_pkg.sv
// acc_pkg -- shared definitions for the acc_reduce reduction stage.
//   state_e      : two-state group FSM (IDLE = empty group, ACCUM = partial group)
//   COUNT_MIN    : smallest legal group size; COUNT=0 is raised to this value
//   norm_count() : effective group size after normalisation
//   cnt_width()  : bit width of the in-group token counter
package acc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    localparam int unsigned COUNT_MIN = 1;

    function automatic int unsigned norm_count(input int unsigned count);
        return (count < COUNT_MIN) ? COUNT_MIN : count;
    endfunction

    // Wide enough to hold 0..COUNT; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned count);
        return $clog2(norm_count(count) + 1);
    endfunction

endpackage

// File: rtl/acc_reduce_sat_add.sv
// sat_add -- OW-wide unsigned adder used by acc_reduce for both the token
// and the flush path.
//   a_i   : accumulator operand
//   b_i   : zero-extended token operand (0 on bubble cycles)
//   sum_o : a_i + b_i, wrapping modulo 2^OW by default
//   ovf_o : carry out of the raw add (only with ACC_REDUCE_SAT_EN)
// Macro ACC_REDUCE_SAT_EN: when defined the sum clamps at 2^OW-1 and the
// overflow flag port exists; when undefined the sum wraps and there is no flag.
module sat_add #(
    parameter int unsigned OW = 18
) (
    input  logic [OW-1:0] a_i,
    input  logic [OW-1:0] b_i,
`ifdef ACC_REDUCE_SAT_EN
    output logic          ovf_o,
`endif
    output logic [OW-1:0] sum_o
);

`ifdef ACC_REDUCE_SAT_EN
    logic [OW:0] raw;

    always_comb begin
        raw   = {1'b0, a_i} + {1'b0, b_i};
        ovf_o = raw[OW];
        sum_o = raw[OW] ? '1 : raw[OW-1:0];
    end
`else
    always_comb begin
        sum_o = a_i + b_i;
    end
`endif

endmodule

// File: rtl/acc_reduce.sv
// acc_reduce -- accumulates COUNT valid tokens into an OW-bit unsigned sum and
// emits one result token per group, with FLUSH to emit a partial group.
//   CLK     : clock, rising edge
//   RST     : synchronous active-low reset (independent of EN)
//   EN      : stage enable; 0 freezes every register including R_OUT
//   R_IN1   : input token valid
//   D_IN1   : input token data (N bits, unsigned)
//   FLUSH   : emit the partial group (sampled only when EN=1)
//   R_OUT   : one-cycle result-valid pulse (stretched while EN=0)
//   D_OUT   : result sum, holds between pulses
//   SAT_OUT : (ACC_REDUCE_SAT_EN only) 1 if any add in the emitted group clamped
// Macro ACC_REDUCE_SAT_EN selects the saturating accumulator and SAT_OUT port.
module acc_reduce
    import acc_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned COUNT = 4,
    parameter int unsigned OW    = 18
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic          R_IN1,
    input  logic [N-1:0]  D_IN1,
    input  logic          FLUSH,
    output logic          R_OUT,
`ifdef ACC_REDUCE_SAT_EN
    output logic          SAT_OUT,
`endif
    output logic [OW-1:0] D_OUT
);

    localparam int unsigned CNT_N = norm_count(COUNT);
    localparam int unsigned CW    = cnt_width(COUNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_N - 1);

    state_e        state_q, state_d;
    logic [OW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rout_q, rout_d;
    logic [OW-1:0] dout_q, dout_d;

    logic [OW-1:0] addend;
    logic [OW-1:0] sum_next;
    logic          emit;

    // Bubbles add zero, so sum_next equals acc on R_IN1=0 cycles.
    assign addend = R_IN1 ? OW'(D_IN1) : '0;

`ifdef ACC_REDUCE_SAT_EN
    logic add_ovf;
    logic grp_sat_q, grp_sat_d;
    logic sat_q, sat_d;

    sat_add #(.OW(OW)) u_add (
        .a_i   (acc_q),
        .b_i   (addend),
        .ovf_o (add_ovf),
        .sum_o (sum_next)
    );
`else
    sat_add #(.OW(OW)) u_add (
        .a_i   (acc_q),
        .b_i   (addend),
        .sum_o (sum_next)
    );
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        rout_d  = rout_q;
        dout_d  = dout_q;
        emit    = 1'b0;
`ifdef ACC_REDUCE_SAT_EN
        grp_sat_d = grp_sat_q;
        sat_d     = sat_q;
`endif
        if (EN) begin
            rout_d = 1'b0;
            // FLUSH and the last token together collapse into one emit.
            if (FLUSH) begin
                emit = (state_q == ACCUM) || R_IN1;
            end else begin
                emit = R_IN1 && (cnt_q == CNT_LAST);
            end

            if (emit) begin
                dout_d  = sum_next;
                rout_d  = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
`ifdef ACC_REDUCE_SAT_EN
                sat_d     = grp_sat_q | add_ovf;
                grp_sat_d = 1'b0;
`endif
            end else if (R_IN1) begin
                acc_d   = sum_next;
                cnt_d   = cnt_q + CW'(1);
                state_d = ACCUM;
`ifdef ACC_REDUCE_SAT_EN
                grp_sat_d = grp_sat_q | add_ovf;
`endif
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            rout_q  <= 1'b0;
            dout_q  <= '0;
`ifdef ACC_REDUCE_SAT_EN
            grp_sat_q <= 1'b0;
            sat_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            rout_q  <= rout_d;
            dout_q  <= dout_d;
`ifdef ACC_REDUCE_SAT_EN
            grp_sat_q <= grp_sat_d;
            sat_q     <= sat_d;
`endif
        end
    end

    assign R_OUT = rout_q;
    assign D_OUT = dout_q;
`ifdef ACC_REDUCE_SAT_EN
    assign SAT_OUT = sat_q;
`endif

endmodule

// File: tb/tb_acc_reduce.sv
// tb_acc_reduce -- scoreboard bench for acc_reduce.
// Three instances: default (N=16, COUNT=4, OW=18), overflow (OW=16, COUNT=2)
// and COUNT=0 (treated as 1). Expected results are queued when the emitting
// token is driven; negedge monitors pop and compare on each new R_OUT pulse.
// Honours ACC_REDUCE_SAT_EN for the SAT_OUT port and saturating expectations.
module tb_acc_reduce;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        en0, r0, f0;
    logic [15:0] d0;
    logic        ro0;
    logic [17:0] do0;

    logic        en1, r1, f1;
    logic [15:0] d1;
    logic        ro1;
    logic [15:0] do1;

    logic        en2, r2, f2;
    logic [15:0] d2;
    logic        ro2;
    logic [17:0] do2;

`ifdef ACC_REDUCE_SAT_EN
    logic sat0, sat1, sat2;
    localparam bit SATM = 1'b1;
`else
    localparam bit SATM = 1'b0;
`endif

    acc_reduce #(.N(16), .COUNT(4), .OW(18)) u0 (
        .CLK(clk), .RST(rst), .EN(en0), .R_IN1(r0), .D_IN1(d0), .FLUSH(f0),
        .R_OUT(ro0),
`ifdef ACC_REDUCE_SAT_EN
        .SAT_OUT(sat0),
`endif
        .D_OUT(do0)
    );

    acc_reduce #(.N(16), .COUNT(2), .OW(16)) u1 (
        .CLK(clk), .RST(rst), .EN(en1), .R_IN1(r1), .D_IN1(d1), .FLUSH(f1),
        .R_OUT(ro1),
`ifdef ACC_REDUCE_SAT_EN
        .SAT_OUT(sat1),
`endif
        .D_OUT(do1)
    );

    acc_reduce #(.N(16), .COUNT(0), .OW(18)) u2 (
        .CLK(clk), .RST(rst), .EN(en2), .R_IN1(r2), .D_IN1(d2), .FLUSH(f2),
        .R_OUT(ro2),
`ifdef ACC_REDUCE_SAT_EN
        .SAT_OUT(sat2),
`endif
        .D_OUT(do2)
    );

    typedef struct {
        logic [17:0] d;
        logic        s;
        int          e;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic rst_s = 1'b0;
    logic en0_s = 1'b0, en1_s = 1'b0, en2_s = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst;
        en0_s <= en0;
        en1_s <= en1;
        en2_s <= en2;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // A pulse is new only if the edge that produced it had EN=1 and no reset.
    always @(negedge clk) begin : mon0
        exp_t x;
        if (rst_s && en0_s && ro0) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL u0_unexpected actual=pulse d=%0h required=none", do0);
            end else begin
                x = q0.pop_front();
                chk("u0_data", 32'(do0), 32'(x.d));
                chk("u0_edge", cyc, x.e);
`ifdef ACC_REDUCE_SAT_EN
                chk("u0_sat", 32'(sat0), 32'(x.s));
`endif
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t x;
        if (rst_s && en1_s && ro1) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL u1_unexpected actual=pulse d=%0h required=none", do1);
            end else begin
                x = q1.pop_front();
                chk("u1_data", 32'(do1), 32'(x.d));
                chk("u1_edge", cyc, x.e);
`ifdef ACC_REDUCE_SAT_EN
                chk("u1_sat", 32'(sat1), 32'(x.s));
`endif
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t x;
        if (rst_s && en2_s && ro2) begin
            if (q2.size() == 0) begin
                total++; bad++;
                $display("FAIL u2_unexpected actual=pulse d=%0h required=none", do2);
            end else begin
                x = q2.pop_front();
                chk("u2_data", 32'(do2), 32'(x.d));
                chk("u2_edge", cyc, x.e);
`ifdef ACC_REDUCE_SAT_EN
                chk("u2_sat", 32'(sat2), 32'(x.s));
`endif
            end
        end
    end

    // Drive one cycle of stimulus, then land 1 time unit after the edge.
    task automatic s0(input logic e, input logic r, input logic f, input logic [15:0] d);
        en0 = e; r0 = r; f0 = f; d0 = d;
        @(posedge clk); #1;
    endtask
    task automatic s1(input logic e, input logic r, input logic f, input logic [15:0] d);
        en1 = e; r1 = r; f1 = f; d1 = d;
        @(posedge clk); #1;
    endtask
    task automatic s2(input logic e, input logic r, input logic f, input logic [15:0] d);
        en2 = e; r2 = r; f2 = f; d2 = d;
        @(posedge clk); #1;
    endtask

    // Expected result of the token driven next, due on the coming edge.
    task automatic p0(input logic [17:0] v, input logic s);
        q0.push_back('{d: v, s: s, e: cyc + 1});
    endtask
    task automatic p1(input logic [17:0] v, input logic s);
        q1.push_back('{d: v, s: s, e: cyc + 1});
    endtask
    task automatic p2(input logic [17:0] v, input logic s);
        q2.push_back('{d: v, s: s, e: cyc + 1});
    endtask

    initial begin
        rst = 1'b0;
        en0 = 1'b1; r0 = 1'b0; f0 = 1'b0; d0 = '0;
        en1 = 1'b1; r1 = 1'b0; f1 = 1'b0; d1 = '0;
        en2 = 1'b1; r2 = 1'b0; f2 = 1'b0; d2 = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ro0", 32'(ro0), 0);
        chk("rst_do0", 32'(do0), 0);
        chk("rst_ro1", 32'(ro1), 0);
        chk("rst_do1", 32'(do1), 0);
        chk("rst_ro2", 32'(ro2), 0);
        chk("rst_do2", 32'(do2), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Group 1,2,3,4 then back-to-back 5,6,7,8
        s0(1, 1, 0, 16'd1); s0(1, 1, 0, 16'd2); s0(1, 1, 0, 16'd3);
        p0(18'd10, 1'b0); s0(1, 1, 0, 16'd4);
        s0(1, 1, 0, 16'd5); s0(1, 1, 0, 16'd6); s0(1, 1, 0, 16'd7);
        p0(18'd26, 1'b0); s0(1, 1, 0, 16'd8);
        s0(1, 0, 0, 16'd0);
        chk("idle_ro0", 32'(ro0), 0);
        chk("idle_do0_hold", 32'(do0), 32'd26);

        // 0xFFFF x4 with a bubble and a 3-cycle stall (FLUSH ignored while stalled)
        s0(1, 1, 0, 16'hFFFF); s0(1, 1, 0, 16'hFFFF);
        s0(1, 0, 0, 16'h1234);
        s0(1, 1, 0, 16'hFFFF);
        s0(0, 0, 1, 16'd0); s0(0, 0, 1, 16'd0); s0(0, 0, 0, 16'd0);
        p0(18'h3FFFC, 1'b0); s0(1, 1, 0, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            s0(0, 0, 0, 16'd0);
            chk("stall_ro0", 32'(ro0), 1);
            chk("stall_do0", 32'(do0), 32'h3FFFC);
        end
        s0(1, 0, 0, 16'd0);
        chk("post_stall_ro0", 32'(ro0), 0);
        chk("post_stall_do0", 32'(do0), 32'h3FFFC);

        // FLUSH partial group, FLUSH in IDLE, FLUSH with a token
        s0(1, 1, 0, 16'd5); s0(1, 1, 0, 16'd7);
        p0(18'd12, 1'b0); s0(1, 0, 1, 16'd0);
        s0(1, 0, 1, 16'd0);
        chk("flush_idle_ro0", 32'(ro0), 0);
        s0(1, 1, 0, 16'd3);
        p0(18'd12, 1'b0); s0(1, 1, 1, 16'd9);
        // Full group afterwards proves cnt restarted at 0
        s0(1, 1, 0, 16'd1); s0(1, 1, 0, 16'd1); s0(1, 1, 0, 16'd1);
        p0(18'd4, 1'b0); s0(1, 1, 0, 16'd1);
        // FLUSH coinciding with the COUNT-th token: single emit
        s0(1, 1, 0, 16'd2); s0(1, 1, 0, 16'd2); s0(1, 1, 0, 16'd2);
        p0(18'd8, 1'b0); s0(1, 1, 1, 16'd2);
        s0(1, 0, 0, 16'd0);
        chk("no_double_ro0", 32'(ro0), 0);

        // Reset mid-group (EN low to show reset ignores EN)
        s0(1, 1, 0, 16'd1); s0(1, 1, 0, 16'd2);
        rst = 1'b0;
        s0(0, 0, 0, 16'd0);
        chk("midrst_ro0", 32'(ro0), 0);
        chk("midrst_do0", 32'(do0), 0);
        rst = 1'b1;
        s0(1, 1, 0, 16'd10); s0(1, 1, 0, 16'd20); s0(1, 1, 0, 16'd30);
        p0(18'd100, 1'b0); s0(1, 1, 0, 16'd40);
        s0(1, 0, 0, 16'd0);

        // Overflow, OW=16 COUNT=2
        s1(1, 1, 0, 16'hFFFF);
        p1(SATM ? 18'h0FFFF : 18'h00000, SATM); s1(1, 1, 0, 16'h0001);
        s1(1, 1, 0, 16'h0001);
        p1(18'd2, 1'b0); s1(1, 1, 0, 16'h0001);
        s1(1, 0, 0, 16'd0);

        // COUNT=0 behaves as 1: pass-through with 1-cycle latency
        s2(1, 0, 1, 16'd0);
        p2(18'd3, 1'b0); s2(1, 1, 0, 16'd3);
        p2(18'd4, 1'b0); s2(1, 1, 0, 16'd4);
        p2(18'd7, 1'b0); s2(1, 1, 1, 16'd7);
        s2(1, 0, 0, 16'd0);
        chk("c1_ro2_idle", 32'(ro2), 0);
        chk("c1_do2_hold", 32'(do2), 32'd7);

        s0(1, 0, 0, 16'd0); s0(1, 0, 0, 16'd0);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
